// File: rtl/tx_mac_lite_ctrl_unit.sv
// TX MAC lite control and statistics unit.
// Decides forward/discard for each frame descriptor from the MI-programmed
// enable and the min/max length limits, hands the decision to the datapath
// through a one-entry handshaked slice, and keeps 64-bit wrapping frame/byte/
// discard counters that software reads through snapshot registers over MI32.
module tx_mac_lite_ctrl_unit #(
  parameter int MIN_LEN     = 60,
  parameter int MTU_DEFAULT = 1526,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  // MI32 register port
  input  logic [31:0]          MI_DWR,
  input  logic [31:0]          MI_ADDR,
  input  logic                 MI_RD,
  input  logic                 MI_WR,
  input  logic [3:0]           MI_BE,
  output logic [31:0]          MI_DRD,
  output logic                 MI_ARDY,
  output logic                 MI_DRDY,
  // frame descriptors from the MFB side
  input  logic [LEN_WIDTH-1:0] FRAME_LEN,
  input  logic                 FRAME_VLD,
  output logic                 FRAME_RDY,
  // decision towards the datapath
  output logic                 OUT_DISCARD,
  output logic                 OUT_VLD,
  input  logic                 OUT_RDY,
  input  logic                 DP_BUSY
);

  // Register word indices (MI_ADDR[5:2]).
  localparam logic [3:0] A_ENABLE  = 4'd0;
  localparam logic [3:0] A_STATUS  = 4'd1;
  localparam logic [3:0] A_CMD     = 4'd2;
  localparam logic [3:0] A_MTU     = 4'd3;
  localparam logic [3:0] A_SF_LO   = 4'd4;
  localparam logic [3:0] A_SF_HI   = 4'd5;
  localparam logic [3:0] A_SB_LO   = 4'd6;
  localparam logic [3:0] A_SB_HI   = 4'd7;
  localparam logic [3:0] A_DF_LO   = 4'd8;
  localparam logic [3:0] A_DF_HI   = 4'd9;

  localparam logic [LEN_WIDTH-1:0] L_MIN_LEN     = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] L_MTU_DEFAULT = LEN_WIDTH'(MTU_DEFAULT);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUN      = 2'd1,
    ST_DRAINING = 2'd2
  } state_t;

  // MI decode
  logic [3:0]            w_reg_idx;
  logic                  w_wr_enable;
  logic                  w_wr_cmd;
  logic                  w_wr_mtu;
  logic                  w_cmd_snap;
  logic                  w_cmd_clear;
  logic [31:0]           w_rd_data;

  // configuration and control state
  logic                  r_enable;
  logic [LEN_WIDTH-1:0]  r_mtu;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [31:0]           w_status;

  // decision slice
  logic                  w_accept_p0;
  logic                  w_too_short_p0;
  logic                  w_too_long_p0;
  logic                  w_discard_p0;
  logic                  r_vld_p1;
  logic                  r_discard_p1;

  // live counters and their snapshots
  logic [63:0]           r_sent_frames;
  logic [63:0]           r_sent_bytes;
  logic [63:0]           r_disc_frames;
  logic [63:0]           r_snap_sent_frames;
  logic [63:0]           r_snap_sent_bytes;
  logic [63:0]           r_snap_disc_frames;

  // MI read return
  logic                  r_mi_drdy;
  logic [31:0]           r_mi_drd;

  // Byte enables are not used (full-word writes only); address bits outside
  // [5:2] are not decoded, so registers alias across the address space.
  logic                  w_unused;
  assign w_unused = ^{MI_BE, MI_ADDR, MI_DWR};

  // Decode the addressed register and the write strobes for this cycle.
  always_comb begin
    w_reg_idx   = MI_ADDR[5:2];
    w_wr_enable = MI_WR && (w_reg_idx == A_ENABLE);
    w_wr_cmd    = MI_WR && (w_reg_idx == A_CMD);
    w_wr_mtu    = MI_WR && (w_reg_idx == A_MTU);
    w_cmd_snap  = w_wr_cmd && MI_DWR[0];
    w_cmd_clear = w_wr_cmd && MI_DWR[1];
  end

  assign MI_ARDY = MI_RD | MI_WR;

  // ENABLE and MTU configuration registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_enable <= 1'b0;
      r_mtu    <= L_MTU_DEFAULT;
    end else begin
      if (w_wr_enable) r_enable <= MI_DWR[0];
      if (w_wr_mtu)    r_mtu    <= MI_DWR[LEN_WIDTH-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_DISABLED;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: a drain completes once no decision is pending and the
  // datapath reports no frames in flight; re-enabling aborts the drain.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_DISABLED: begin
        if (w_wr_enable && MI_DWR[0]) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_wr_enable && !MI_DWR[0]) w_state_nxt = ST_DRAINING;
      end
      ST_DRAINING: begin
        if (w_wr_enable && MI_DWR[0])    w_state_nxt = ST_RUN;
        else if (!r_vld_p1 && !DP_BUSY)  w_state_nxt = ST_DISABLED;
      end
      default: w_state_nxt = ST_DISABLED;
    endcase
  end

  // FSM outputs: the STATUS word.
  always_comb begin
    w_status    = 32'd0;
    w_status[0] = (r_state != ST_DISABLED);
    w_status[1] = (r_state == ST_DISABLED);
    w_status[2] = (r_state == ST_DRAINING);
  end

  // Stage p0: accept and classify the offered descriptor. The decision uses
  // the registered enable, so a same-cycle ENABLE write affects only later
  // frames.
  always_comb begin
    FRAME_RDY      = !r_vld_p1 || OUT_RDY;
    w_accept_p0    = FRAME_VLD && FRAME_RDY;
    w_too_short_p0 = (FRAME_LEN < L_MIN_LEN);
    w_too_long_p0  = (FRAME_LEN > r_mtu);
    w_discard_p0   = !r_enable || w_too_short_p0 || w_too_long_p0;
  end

  // Stage p1: decision slice; holds while the datapath stalls.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vld_p1     <= 1'b0;
      r_discard_p1 <= 1'b0;
    end else if (FRAME_RDY) begin
      r_vld_p1 <= FRAME_VLD;
      if (FRAME_VLD) r_discard_p1 <= w_discard_p0;
    end
  end

  assign OUT_VLD     = r_vld_p1;
  assign OUT_DISCARD = r_discard_p1;

  // Live counters: clear wins over a same-cycle increment.
  always_ff @(posedge CLK) begin
    if (RESET || w_cmd_clear) begin
      r_sent_frames <= 64'd0;
      r_sent_bytes  <= 64'd0;
      r_disc_frames <= 64'd0;
    end else if (w_accept_p0) begin
      if (w_discard_p0) begin
        r_disc_frames <= r_disc_frames + 64'd1;
      end else begin
        r_sent_frames <= r_sent_frames + 64'd1;
        r_sent_bytes  <= r_sent_bytes + 64'(FRAME_LEN);
      end
    end
  end

  // Snapshot copies the pre-update counters, so it excludes a frame accepted
  // in the same cycle and captures pre-clear values when CMD=0x3.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_snap_sent_frames <= 64'd0;
      r_snap_sent_bytes  <= 64'd0;
      r_snap_disc_frames <= 64'd0;
    end else if (w_cmd_snap) begin
      r_snap_sent_frames <= r_sent_frames;
      r_snap_sent_bytes  <= r_sent_bytes;
      r_snap_disc_frames <= r_disc_frames;
    end
  end

  // MI read multiplexer over the current (pre-write) register contents.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_reg_idx)
      A_ENABLE: w_rd_data = {31'd0, r_enable};
      A_STATUS: w_rd_data = w_status;
      A_CMD:    w_rd_data = 32'd0;
      A_MTU:    w_rd_data = 32'(r_mtu);
      A_SF_LO:  w_rd_data = r_snap_sent_frames[31:0];
      A_SF_HI:  w_rd_data = r_snap_sent_frames[63:32];
      A_SB_LO:  w_rd_data = r_snap_sent_bytes[31:0];
      A_SB_HI:  w_rd_data = r_snap_sent_bytes[63:32];
      A_DF_LO:  w_rd_data = r_snap_disc_frames[31:0];
      A_DF_HI:  w_rd_data = r_snap_disc_frames[63:32];
      default:  w_rd_data = 32'd0;
    endcase
  end

  // MI read return register: data and valid one cycle after MI_RD.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mi_drdy <= 1'b0;
      r_mi_drd  <= 32'd0;
    end else begin
      r_mi_drdy <= MI_RD;
      r_mi_drd  <= MI_RD ? w_rd_data : 32'd0;
    end
  end

  assign MI_DRDY = r_mi_drdy;
  assign MI_DRD  = r_mi_drd;

endmodule
